// File: rtl/div_operand_stage.sv
// Operand staging FIFO for a single-precision divider: buffers two dividend/divisor
// pairs and classifies each at push. Optional macro DIV_DENORM_FLUSH_EN flushes subnormals to signed zero.
module div_operand_stage (
  input  logic        control,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] DD_in,
  input  logic [31:0] DS_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] DD,
  output logic [31:0] DS,
  output logic        special,
  output logic [31:0] special_result,
  output logic        zeroDiv,
  output logic [7:0]  zero_div_count,
  output logic [1:0]  occupancy
);

`ifdef DIV_DENORM_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] dd;
    logic [31:0] ds;
    logic        spec;
    logic [31:0] res;
    logic        zd;
  } entry_t;

  function automatic logic [31:0] flush_sub(input logic [31:0] x);
    if (FLUSH_EN && (x[30:23] == 8'h00))
      return {x[31], 31'b0};
    else
      return x;
  endfunction

  function automatic entry_t classify(input logic [31:0] a_raw, input logic [31:0] b_raw);
    entry_t      e;
    logic [31:0] a;
    logic [31:0] b;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    a      = flush_sub(a_raw);
    b      = flush_sub(b_raw);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_zero = (a[30:0] == 31'h0);
    b_zero = (b[30:0] == 31'h0);
    sgn    = a[31] ^ b[31];
    e.dd   = a;
    e.ds   = b;
    e.spec = 1'b1;
    e.zd   = 1'b0;
    // Order matters: invalid cases first, then divide-by-zero, then exact zero/inf results.
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      e.res = QNAN;
    end else if (b_zero) begin
      e.res = {sgn, 8'hFF, 23'h0};
      e.zd  = 1'b1;
    end else if (a_zero || b_inf) begin
      e.res = {sgn, 31'h0};
    end else if (a_inf) begin
      e.res = {sgn, 8'hFF, 23'h0};
    end else begin
      e.spec = 1'b0;
      e.res  = 32'h0;
    end
    return e;
  endfunction

  entry_t      r_ent [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_occ;
  logic [7:0]  r_zcnt;

  logic        w_push;
  logic        w_pop;
  entry_t      w_head;
  entry_t      w_new;

  assign in_ready  = reset & ~r_occ[1] & ~clear;
  assign out_valid = (r_occ != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_new     = classify(DD_in, DS_in);
  assign w_head    = r_ent[r_rptr];

  // Control state: pointers, occupancy and the zero-divide counter.
  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
      r_zcnt <= 8'd0;
    end else if (clear) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      if (w_pop && w_head.zd && (r_zcnt != 8'hFF))
        r_zcnt <= r_zcnt + 8'd1;
    end
  end

  // Storage is not reset; stale entries are hidden by the occupancy gating below.
  always_ff @(posedge control) begin
    if (w_push)
      r_ent[r_wptr] <= w_new;
  end

  assign DD             = out_valid ? w_head.dd   : 32'h0;
  assign DS             = out_valid ? w_head.ds   : 32'h0;
  assign special        = out_valid ? w_head.spec : 1'b0;
  assign special_result = out_valid ? w_head.res  : 32'h0;
  assign zeroDiv        = out_valid ? w_head.zd   : 1'b0;
  assign zero_div_count = r_zcnt;
  assign occupancy      = r_occ;

endmodule
